// File: rtl/debug_ctrl_pkg.sv
// Shared types and defaults for the debug access controller: address spaces,
// FSM states and the halt timeout default.
package debug_ctrl_pkg;

    typedef enum logic [1:0] {
        SPACE_REG  = 2'd0,
        SPACE_DMEM = 2'd1,
        SPACE_IMEM = 2'd2,
        SPACE_PC   = 2'd3
    } dbg_space_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HALT    = 3'd1,
        ST_ACCESS  = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_RESPOND = 3'd4
    } dbg_state_e;

    localparam int HALT_TIMEOUT_DEF = 15;

endpackage

// File: rtl/debug_access_controller_if.sv
// Host request/response channel plus the subsystem debug port of the debug
// access controller, with the FSM state exposed for observation.
interface debug_access_controller_if
    import debug_ctrl_pkg::*;
#(
    parameter int DATA_W         = 8,
    parameter int INST_W         = 16,
    parameter int D_ADDR_W       = 12,
    parameter int I_ADDR_W       = 12,
    parameter int REG_ADDR_WIDTH = 4,
    parameter int ADDR_W         = (D_ADDR_W > I_ADDR_W) ? D_ADDR_W : I_ADDR_W
);
    // Both channels use valid/ready: a transfer happens on a rising clock edge
    // where valid and ready are both 1; valid and its payload stay stable until then.
    logic                      req_valid;
    logic                      req_ready;
    logic [1:0]                req_space;
    logic [ADDR_W-1:0]         req_addr;
    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [INST_W-1:0]         rsp_data;
    logic                      rsp_error;

    logic                      halt_req;
    logic                      halted;
    logic                      debug_enable;
    logic [REG_ADDR_WIDTH-1:0] reg_debug_addr;
    logic [D_ADDR_W-1:0]       dmem_debug_addr;
    logic [I_ADDR_W-1:0]       imem_debug_addr;
    logic [DATA_W-1:0]         reg_debug_rdata;
    logic [DATA_W-1:0]         dmem_debug_rdata;
    logic [INST_W-1:0]         imem_debug_rdata;
    logic [I_ADDR_W-1:0]       pc;

    dbg_state_e                state_dbg;

    modport slave (
        input  req_valid, req_space, req_addr, rsp_ready, halted,
               reg_debug_rdata, dmem_debug_rdata, imem_debug_rdata, pc,
        output req_ready, rsp_valid, rsp_data, rsp_error, halt_req, debug_enable,
               reg_debug_addr, dmem_debug_addr, imem_debug_addr, state_dbg
    );

    modport master (
        output req_valid, req_space, req_addr, rsp_ready, halted,
               reg_debug_rdata, dmem_debug_rdata, imem_debug_rdata, pc,
        input  req_ready, rsp_valid, rsp_data, rsp_error, halt_req, debug_enable,
               reg_debug_addr, dmem_debug_addr, imem_debug_addr, state_dbg
    );

endinterface

// File: rtl/debug_access_controller.sv
// Sequences one host debug read at a time: halt the core, read the selected
// space through the subsystem debug port, respond, then release the halt.
module debug_access_controller
    import debug_ctrl_pkg::*;
#(
    parameter int DATA_W         = 8,
    parameter int INST_W         = 16,
    parameter int D_ADDR_W       = 12,
    parameter int I_ADDR_W       = 12,
    parameter int REG_ADDR_WIDTH = 4,
    parameter int ADDR_W         = (D_ADDR_W > I_ADDR_W) ? D_ADDR_W : I_ADDR_W,
    parameter int HALT_TIMEOUT   = HALT_TIMEOUT_DEF
) (
    input  logic                        clk,
    input  logic                        reset_n,
    debug_access_controller_if.slave    bus
);

    localparam int                CNT_W    = $clog2(HALT_TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(HALT_TIMEOUT - 1);
    localparam logic [ADDR_W-1:0] REG_OK_MASK  = ADDR_W'((64'd1 << REG_ADDR_WIDTH) - 64'd1);
    localparam logic [ADDR_W-1:0] DMEM_OK_MASK = ADDR_W'((64'd1 << D_ADDR_W) - 64'd1);

    dbg_state_e        state_q, state_d;
    dbg_space_e        space_q, space_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [INST_W-1:0] data_q, data_d;
    logic              err_q, err_d;
    logic              halt_q, halt_d;
    logic              den_q, den_d;
    logic              live_q;

    logic              bad_addr;
    logic              drive_addr;
    logic [INST_W-1:0] capture_val;

    always_comb begin
        bad_addr = 1'b0;
        case (dbg_space_e'(bus.req_space))
            SPACE_REG:  bad_addr = |(bus.req_addr & ~REG_OK_MASK);
            SPACE_DMEM: bad_addr = |(bus.req_addr & ~DMEM_OK_MASK);
            default:    bad_addr = 1'b0;
        endcase
    end

    // Read data arrives one cycle after the address, so it is valid in CAPTURE.
    always_comb begin
        capture_val = '0;
        case (space_q)
            SPACE_REG:  capture_val = INST_W'(bus.reg_debug_rdata);
            SPACE_DMEM: capture_val = INST_W'(bus.dmem_debug_rdata);
            SPACE_IMEM: capture_val = bus.imem_debug_rdata;
            default:    capture_val = INST_W'(bus.pc);
        endcase
    end

    always_comb begin
        state_d = state_q;
        space_d = space_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        err_d   = err_q;
        halt_d  = halt_q;
        den_d   = den_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid && live_q) begin
                    space_d = dbg_space_e'(bus.req_space);
                    addr_d  = bus.req_addr;
                    data_d  = '0;
                    cnt_d   = '0;
                    if (bad_addr) begin
                        err_d   = 1'b1;
                        state_d = ST_RESPOND;
                    end else begin
                        err_d   = 1'b0;
                        halt_d  = 1'b1;
                        state_d = ST_HALT;
                    end
                end
            end
            ST_HALT: begin
                // A late halted on the final HALT cycle still wins over the timeout.
                if (bus.halted) begin
                    den_d   = 1'b1;
                    state_d = ST_ACCESS;
                end else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    state_d = ST_RESPOND;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_ACCESS: state_d = ST_CAPTURE;
            ST_CAPTURE: begin
                data_d  = capture_val;
                state_d = ST_RESPOND;
            end
            ST_RESPOND: begin
                if (bus.rsp_ready) begin
                    data_d  = '0;
                    err_d   = 1'b0;
                    halt_d  = 1'b0;
                    den_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            space_q <= SPACE_REG;
            addr_q  <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
            halt_q  <= 1'b0;
            den_q   <= 1'b0;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            space_q <= space_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            err_q   <= err_d;
            halt_q  <= halt_d;
            den_q   <= den_d;
            live_q  <= 1'b1;
        end
    end

    // live_q keeps req_ready low while reset is held and until the first clock after it.
    assign drive_addr          = (state_q == ST_ACCESS) || (state_q == ST_CAPTURE);
    assign bus.req_ready       = (state_q == ST_IDLE) && live_q;
    assign bus.rsp_valid       = (state_q == ST_RESPOND);
    assign bus.rsp_data        = data_q;
    assign bus.rsp_error       = err_q;
    assign bus.halt_req        = halt_q;
    assign bus.debug_enable    = den_q;
    assign bus.reg_debug_addr  = (drive_addr && space_q == SPACE_REG)
                                 ? addr_q[REG_ADDR_WIDTH-1:0] : '0;
    assign bus.dmem_debug_addr = (drive_addr && space_q == SPACE_DMEM)
                                 ? addr_q[D_ADDR_W-1:0] : '0;
    assign bus.imem_debug_addr = (drive_addr && space_q == SPACE_IMEM)
                                 ? addr_q[I_ADDR_W-1:0] : '0;
    assign bus.state_dbg       = state_q;

endmodule

// File: tb/tb_debug_access_controller.sv
// Directed bench for debug_access_controller: expected responses are queued at
// issue time and checked by an independent response monitor.
module tb_debug_access_controller;
    import debug_ctrl_pkg::*;

    localparam int HT = 15;

    logic clk     = 1'b0;
    logic reset_n = 1'b1;
    int   cyc     = 0;
    int   n_cmp   = 0;
    int   n_fail  = 0;

    // Packed expectation: {error, data[15:0], latency[7:0]}
    logic [24:0] exp_q[$];

    debug_access_controller_if bus ();

    debug_access_controller #(.HALT_TIMEOUT(HT)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Subsystem model with one-cycle synchronous read latency.
    always @(posedge clk) begin
        bus.reg_debug_rdata  <= 8'hA2 + 8'(bus.reg_debug_addr);
        bus.dmem_debug_rdata <= bus.dmem_debug_addr[7:0] ^ 8'h5A;
        bus.imem_debug_rdata <= (bus.imem_debug_addr == 12'h123) ? 16'hBEEF
                                : {4'h0, bus.imem_debug_addr};
    end

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    // Response monitor / scoreboard
    int   acc_cyc = 0;
    int   lat     = 0;
    logic seen    = 1'b0;
    logic [24:0] e;
    initial begin
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                seen = 1'b0;
            end else begin
                if (bus.req_valid && bus.req_ready) acc_cyc = cyc;
                if (bus.rsp_valid && !seen) begin
                    seen = 1'b1;
                    lat  = cyc - acc_cyc;
                end
                if (bus.rsp_valid && bus.rsp_ready) begin
                    seen = 1'b0;
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL unexpected_rsp: got data 0x%0h err %0b with nothing expected",
                                 bus.rsp_data, bus.rsp_error);
                    end else begin
                        e = exp_q.pop_front();
                        chk("rsp_error", 32'(bus.rsp_error), 32'(e[24]));
                        chk("rsp_data", 32'(bus.rsp_data), 32'(e[23:8]));
                        chk("rsp_latency", lat, 32'(e[7:0]));
                    end
                end
            end
        end
    end

    task automatic do_req(input logic [1:0] sp, input logic [11:0] a,
                          input logic push, input logic [24:0] ex);
        logic ok;
        ok = 1'b0;
        @(posedge clk); #1;
        if (push) exp_q.push_back(ex);
        bus.req_space = sp;
        bus.req_addr  = a;
        bus.req_valid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = bus.req_ready;
        end
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        bus.req_space = '0;
        bus.req_addr  = '0;
        if (!ok) begin
            n_cmp++;
            n_fail++;
            $display("FAIL req_accept: got req_ready 0 for 50 cycles, required 1");
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL rsp_wait: got %0d pending responses after 200 cycles, required 0",
                     exp_q.size());
            exp_q.delete();
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.req_valid = 1'b0;
        bus.req_space = '0;
        bus.req_addr  = '0;
        bus.rsp_ready = 1'b1;
        bus.halted    = 1'b1;
        bus.pc        = 12'h3C4;

        // Reset state
        #1 reset_n = 1'b0;
        #2;
        chk("rst_req_ready", 32'(bus.req_ready), 0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
        chk("rst_halt_req", 32'(bus.halt_req), 0);
        chk("rst_debug_en", 32'(bus.debug_enable), 0);
        chk("rst_rsp_data", 32'(bus.rsp_data), 0);
        repeat (2) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_req_ready", 32'(bus.req_ready), 1);
        chk("post_rst_halt_req", 32'(bus.halt_req), 0);

        // REG addr 3 with halted tied high: minimum latency and per-cycle trace
        do_req(2'd0, 12'h003, 1'b1, {1'b0, 16'h00A5, 8'd4});
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            chk($sformatf("t1_reg_addr_c%0d", k), 32'(bus.reg_debug_addr), (k == 2 || k == 3) ? 3 : 0);
            chk($sformatf("t1_halt_req_c%0d", k), 32'(bus.halt_req), (k <= 4) ? 1 : 0);
            chk($sformatf("t1_debug_en_c%0d", k), 32'(bus.debug_enable), (k >= 2 && k <= 4) ? 1 : 0);
            chk($sformatf("t1_req_ready_c%0d", k), 32'(bus.req_ready), (k == 5) ? 1 : 0);
        end
        wait_idle();

        // IMEM 0x123, halted seen from the third HALT cycle, then falling during ACCESS
        bus.halted = 1'b0;
        do_req(2'd2, 12'h123, 1'b1, {1'b0, 16'hBEEF, 8'd6});
        repeat (2) begin @(posedge clk); #1; end
        bus.halted = 1'b1;
        @(posedge clk); #1;
        bus.halted = 1'b0;
        wait_idle();
        bus.halted = 1'b1;

        // More spaces and the REG address boundary
        do_req(2'd1, 12'h07C, 1'b1, {1'b0, 16'h0026, 8'd4});
        wait_idle();
        do_req(2'd0, 12'h00F, 1'b1, {1'b0, 16'h00B1, 8'd4});
        wait_idle();
        do_req(2'd2, 12'h045, 1'b1, {1'b0, 16'h0045, 8'd4});
        wait_idle();

        // Halt timeout: halted never rises
        bus.halted = 1'b0;
        do_req(2'd0, 12'h001, 1'b1, {1'b1, 16'h0000, 8'(HT + 1)});
        for (int k = 1; k <= HT + 2; k++) begin
            @(negedge clk);
            if (k == HT) chk("to_rsp_valid_early", 32'(bus.rsp_valid), 0);
            if (k == HT + 1) begin
                chk("to_halt_req_held", 32'(bus.halt_req), 1);
                chk("to_rsp_valid", 32'(bus.rsp_valid), 1);
                chk("to_debug_en", 32'(bus.debug_enable), 0);
            end
            if (k == HT + 2) begin
                chk("to_halt_req_drop", 32'(bus.halt_req), 0);
                chk("to_req_ready", 32'(bus.req_ready), 1);
            end
        end
        wait_idle();

        // halted arriving on the last HALT cycle still completes the access
        do_req(2'd0, 12'h003, 1'b1, {1'b0, 16'h00A5, 8'(HT + 3)});
        repeat (HT - 1) begin @(posedge clk); #1; end
        bus.halted = 1'b1;
        wait_idle();

        // Bad REG address: immediate error, no halt
        do_req(2'd0, 12'h010, 1'b1, {1'b1, 16'h0000, 8'd1});
        @(negedge clk);
        chk("bad_halt_req", 32'(bus.halt_req), 0);
        chk("bad_debug_en", 32'(bus.debug_enable), 0);
        chk("bad_rsp_valid", 32'(bus.rsp_valid), 1);
        wait_idle();

        // PC read with response back-pressure; pc changes and a new request are ignored
        bus.rsp_ready = 1'b0;
        bus.pc        = 12'h3C4;
        do_req(2'd3, 12'hFFF, 1'b1, {1'b0, 16'h03C4, 8'd4});
        for (int k = 1; k <= 9; k++) begin
            if (k == 4) begin
                bus.req_valid = 1'b1;
                bus.req_space = 2'd0;
                bus.req_addr  = 12'h005;
            end
            if (k == 5) bus.pc = 12'h111;
            if (k == 9) begin
                bus.req_valid = 1'b0;
                bus.rsp_ready = 1'b1;
            end
            @(negedge clk);
            if (k >= 4 && k <= 8) begin
                chk($sformatf("pc_rsp_valid_c%0d", k), 32'(bus.rsp_valid), 1);
                chk($sformatf("pc_rsp_data_c%0d", k), 32'(bus.rsp_data), 32'h3C4);
                chk($sformatf("pc_halt_req_c%0d", k), 32'(bus.halt_req), 1);
                chk($sformatf("pc_req_ready_c%0d", k), 32'(bus.req_ready), 0);
            end
            if (k < 9) begin @(posedge clk); #1; end
        end
        @(posedge clk); #1;
        @(negedge clk);
        chk("pc_after_req_ready", 32'(bus.req_ready), 1);
        chk("pc_after_halt_req", 32'(bus.halt_req), 0);
        wait_idle();

        // Reset during ACCESS drops the request; the next one completes normally
        do_req(2'd0, 12'h002, 1'b0, '0);
        @(posedge clk); #1;
        chk("mid_debug_en_before", 32'(bus.debug_enable), 1);
        #1 reset_n = 1'b0;
        #1;
        chk("mid_halt_req", 32'(bus.halt_req), 0);
        chk("mid_debug_en", 32'(bus.debug_enable), 0);
        chk("mid_reg_addr", 32'(bus.reg_debug_addr), 0);
        chk("mid_rsp_valid", 32'(bus.rsp_valid), 0);
        chk("mid_req_ready", 32'(bus.req_ready), 0);
        @(negedge clk) reset_n = 1'b1;
        do_req(2'd0, 12'h003, 1'b1, {1'b0, 16'h00A5, 8'd4});
        wait_idle();

        chk("queue_drained", 32'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/debug_access_controller.md
# debug_access_controller

Sequences host debug reads into the Turtle CPU subsystem. Accepts one read request at a time over a valid/ready channel and asks the core to halt. Once the core acknowledges, it drives the subsystem debug port (`debug_enable` plus register, data-memory and instruction-memory debug addresses) and captures the returned value or the PC. It returns the result over a valid/ready response channel, then releases the halt. Sits between a host bridge (e.g. UART) and `turtle_cpu_subsystem`, replacing the tie-offs on the debug port.

## Interface
Parameters:
- `DATA_W`, 8, GPR/data-memory word width
- `INST_W`, 16, instruction word width; also the response data width
- `D_ADDR_W`, 12, data address width
- `I_ADDR_W`, 12, instruction address width
- `REG_ADDR_WIDTH`, 4, debug register address width
- `ADDR_W`, max(`D_ADDR_W`,`I_ADDR_W`), request address width
- `HALT_TIMEOUT`, 15, cycles allowed in HALT before an error response

Ports:
- `clk`  in  1  single clock
- `reset_n`  in  1  asynchronous, active-low reset
- `req_valid`  in  1  host request valid
- `req_ready`  out  1  controller can accept a request
- `req_space`  in  2  address space: 0 REG, 1 DMEM, 2 IMEM, 3 PC
- `req_addr`  in  `ADDR_W`  address within that space; ignored for PC
- `rsp_valid`  out  1  response valid
- `rsp_ready`  in  1  host accepts the response
- `rsp_data`  out  `INST_W`  read value, zero-extended
- `rsp_error`  out  1  request failed (timeout or bad address)
- `halt_req`  out  1  request the core to stall
- `halted`  in  1  core is quiesced
- `debug_enable`  out  1  to subsystem
- `reg_debug_addr`  out  `REG_ADDR_WIDTH`  to subsystem
- `dmem_debug_addr`  out  `D_ADDR_W`  to subsystem
- `imem_debug_addr`  out  `I_ADDR_W`  to subsystem
- `reg_debug_rdata`  in  `DATA_W`  from subsystem
- `dmem_debug_rdata`  in  `DATA_W`  from subsystem
- `imem_debug_rdata`  in  `INST_W`  from subsystem
- `pc`  in  `I_ADDR_W`  from subsystem

## Operation
- States: IDLE, HALT, ACCESS, CAPTURE, RESPOND.
- IDLE:
  - `req_ready`=1; all other outputs are 0.
  - On `req_valid`, latch `req_space` and `req_addr`.
  - If REG and `req_addr[ADDR_W-1:REG_ADDR_WIDTH]`≠0, or DMEM and an address bit at or above `D_ADDR_W` is set: go to RESPOND with `rsp_error`=1, `rsp_data`=0, and never halt.
  - Otherwise go to HALT.
- HALT:
  - `halt_req`=1; the timeout counter clears on entry and increments each cycle.
  - `halted`=1 → ACCESS.
  - Counter reaches `HALT_TIMEOUT` with `halted` still 0 → RESPOND with error and `rsp_data`=0.
- ACCESS, CAPTURE:
  - `debug_enable`=1, with the selected space's address driven from the latch; non-selected addresses stay 0.
  - The subsystem has 1-cycle synchronous read latency: ACCESS presents the address, and the clock edge ending CAPTURE samples the selected rdata (or `pc`) into `rsp_data`, zero-extended.
  - PC space still halts, so the PC snapshot is stable.
- RESPOND:
  - `rsp_valid`=1; `rsp_data` and `rsp_error` are held stable until `rsp_ready`.
  - `halt_req` stays asserted if it was asserted on entry.
  - `rsp_ready` → IDLE; `halt_req` and `debug_enable` drop on that edge.
- `halted` falling after HALT is ignored; the access completes regardless.
- Only one request is outstanding at a time; `req_ready` is 0 outside IDLE.

## Timing
- Reset (async assert, sync deassert): state IDLE, all outputs 0 except `req_ready`=1 once in IDLE; the latched request and counter are cleared.
- Reset mid-operation: the request is dropped with no response, and `halt_req`/`debug_enable` go 0 immediately.
- Minimum latency, with `halted` already 1: accept at cycle 0, HALT at 1, ACCESS at 2, CAPTURE at 3, `rsp_valid` at 4.
- Each cycle that `halted` is late adds one cycle.
- Bad-address error: `rsp_valid` at cycle 1.
- Timeout error: `rsp_valid` at cycle 1+`HALT_TIMEOUT`.
- Next `req_ready`: the cycle after the `rsp_valid`&`rsp_ready` handshake.

## Structure
- `debug_ctrl_pkg`:
  - `dbg_space_e` (REG, DMEM, IMEM, PC; 2 bits)
  - `dbg_state_e`
  - `HALT_TIMEOUT` default constant
- No sub-module is warranted; the FSM, timeout counter and capture mux stay inline.
- The subsystem must expose `halt_req`/`halted`; that addition belongs to the subsystem, not this block.

## Test plan
- REG read addr 3, `halted` tied 1, `reg_debug_rdata`=0xA5:
  - `rsp_data`=0x00A5, no error
  - `rsp_valid` 4 cycles after accept
  - `reg_debug_addr`=3 only in ACCESS/CAPTURE
- IMEM read addr 0x123, `imem_debug_rdata`=0xBEEF, `halted` rising 3 cycles after `halt_req` → `rsp_data`=0xBEEF, `rsp_valid` 2 cycles later than the minimum.
- `halted` held 0 → error response with `rsp_data`=0 exactly `HALT_TIMEOUT`+1 cycles after accept; `halt_req` drops after the handshake.
- REG addr 0x010 → error at cycle 1; `halt_req` never asserts.
- PC read with `rsp_ready` held 0 for 5 cycles:
  - `rsp_valid`, `rsp_data`=`pc` and `halt_req` stable throughout
  - `req_valid` ignored meanwhile
- `reset_n` pulsed low during ACCESS → all outputs 0 in the same cycle; next request completes normally.
